// File: rtl/ranging_pkg.sv
// Shared types and 27 MHz timing defaults for the ultrasonic ranging scheduler.
package ranging_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

  localparam logic [1:0] TO_OK     = 2'b00;
  localparam logic [1:0] TO_NORISE = 2'b01;
  localparam logic [1:0] TO_LONG   = 2'b10;

  localparam int unsigned DEF_NUM_SENSORS    = 4;
  localparam int unsigned DEF_TRIG_CYCLES    = 270;
  localparam int unsigned DEF_ARM_TIMEOUT    = 810000;
  localparam int unsigned DEF_ECHO_MAX       = 1026000;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 1620000;
  localparam int unsigned DEF_CNT_W          = 21;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Per-bit 2-FF synchronizer with a registered previous value for edge detection.
module echo_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_ping_scheduler.sv
// Round-robin trigger/echo sequencer sharing one echo-width timer across all sensors.
module ultrasonic_ping_scheduler
  import ranging_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = DEF_NUM_SENSORS,
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned ARM_TIMEOUT    = DEF_ARM_TIMEOUT,
  parameter int unsigned ECHO_MAX       = DEF_ECHO_MAX,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   single_shot,
  input  logic [2:0]             start_sel,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   busy,
  output logic                   res_valid,
  output logic [2:0]             res_sensor,
  output logic [CNT_W-1:0]       res_count,
  output logic [1:0]             res_timeout,
  output logic [2:0]             dbg_state
);

  // One timer serves every phase, so it must hold the longest interval.
  localparam int unsigned T_MAX = max_u(max_u(TRIG_CYCLES, ARM_TIMEOUT),
                                        max_u(ECHO_MAX, HOLDOFF_CYCLES));
  localparam int unsigned TW    = max_u(unsigned'($clog2(T_MAX + 1)), CNT_W);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0] ARM_LAST  = TW'(ARM_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);
  localparam logic [TW-1:0] ECHO_LIM  = TW'(ECHO_MAX);
  localparam logic [2:0]    PTR_LAST  = 3'(NUM_SENSORS - 1);

  state_e                 state_q, state_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic [2:0]             ptr_q, ptr_d;
  logic                   single_q, single_d;
  logic                   res_valid_q;
  logic [2:0]             res_sensor_q;
  logic [CNT_W-1:0]       res_count_q;
  logic [1:0]             res_timeout_q;

  logic [NUM_SENSORS-1:0] rise_v, fall_v, sel_mask;
  logic                   rise_sel, fall_sel, start_ok;
  logic                   post;
  logic [TW-1:0]          post_count;
  logic [1:0]             post_to;
  logic [2:0]             ptr_next;

  echo_sync #(.W(NUM_SENSORS)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (echo),
    .rise_o  (rise_v),
    .fall_o  (fall_v)
  );

  assign sel_mask = NUM_SENSORS'(1) << ptr_q;
  assign rise_sel = |(rise_v & sel_mask);
  assign fall_sel = |(fall_v & sel_mask);
  assign start_ok = 32'(start_sel) < NUM_SENSORS;
  assign ptr_next = (ptr_q == PTR_LAST) ? 3'd0 : ptr_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    single_d   = single_q;
    post       = 1'b0;
    post_count = '0;
    post_to    = TO_OK;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          single_d = 1'b0;
          state_d  = ST_TRIG;
        end else if (single_shot && start_ok) begin
          ptr_d    = start_sel;
          single_d = 1'b1;
          state_d  = ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RISE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        if (rise_sel) begin
          cnt_d   = TW'(1);
          state_d = ST_MEASURE;
        end else if (cnt_q == ARM_LAST) begin
          post    = 1'b1;
          post_to = TO_NORISE;
          cnt_d   = '0;
          state_d = ST_HOLDOFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        // A fall seen with the counter already at ECHO_MAX still reports as a good echo.
        if (fall_sel || cnt_q == ECHO_LIM) begin
          post       = 1'b1;
          post_count = cnt_q;
          post_to    = fall_sel ? TO_OK : TO_LONG;
          cnt_d      = '0;
          state_d    = ST_HOLDOFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (single_q) begin
            single_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            ptr_d   = ptr_next;
            state_d = enable ? ST_TRIG : ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      single_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_sensor_q  <= '0;
      res_count_q   <= '0;
      res_timeout_q <= TO_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      single_q    <= single_d;
      res_valid_q <= post;
      if (post) begin
        res_sensor_q  <= ptr_q;
        res_count_q   <= post_count[CNT_W-1:0];
        res_timeout_q <= post_to;
      end
    end
  end

  assign trig        = (state_q == ST_TRIG) ? sel_mask : '0;
  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = res_valid_q;
  assign res_sensor  = res_sensor_q;
  assign res_count   = res_count_q;
  assign res_timeout = res_timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ultrasonic_ping_scheduler.sv
// Directed bench: continuous scan, table of single-shot pings, ignored starts, async reset.
module tb_ultrasonic_ping_scheduler;
  import ranging_pkg::*;

  localparam int NS   = 3;
  localparam int TRIG = 4;
  localparam int ARM  = 20;
  localparam int EMAX = 50;
  localparam int HOLD = 10;
  localparam int CW   = 21;

  logic          clk, rst_n, enable, single_shot;
  logic [2:0]    start_sel;
  logic [NS-1:0] echo;
  logic [NS-1:0] trig;
  logic          busy, res_valid;
  logic [2:0]    res_sensor;
  logic [CW-1:0] res_count;
  logic [1:0]    res_timeout;
  logic [2:0]    dbg_state;

  ultrasonic_ping_scheduler #(
    .NUM_SENSORS(NS), .TRIG_CYCLES(TRIG), .ARM_TIMEOUT(ARM),
    .ECHO_MAX(EMAX), .HOLDOFF_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .single_shot(single_shot),
    .start_sel(start_sel), .echo(echo), .trig(trig), .busy(busy),
    .res_valid(res_valid), .res_sensor(res_sensor), .res_count(res_count),
    .res_timeout(res_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    n_checks++;
    if (act < min) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // scoreboard: expected {sensor, count, timeout}
  logic [25:0] exp_q[$];
  int          trig_log[$];
  int          trig_n       = 0;
  int          tw           = 0;
  int          last_res_cyc = 0;
  bit          have_res     = 0;
  logic [NS-1:0] prev_trig  = '0;
  logic        prev_valid   = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      tw         = 0;
      prev_trig  = '0;
      prev_valid = 1'b0;
      have_res   = 0;
    end else begin
      if (trig != '0 && prev_trig == '0) begin
        int idx;
        idx = 0;
        for (int i = 0; i < NS; i++) if (trig[i]) idx = i;
        check("trig_onehot", 32'($countones(trig)), 32'd1);
        if (have_res) check_ge("holdoff_gap", cyc - last_res_cyc, HOLD);
        trig_log.push_back(idx);
        trig_n++;
        tw = 0;
      end
      if (trig != '0) tw++;
      if (trig == '0 && prev_trig != '0) check("trig_width", 32'(tw), 32'(TRIG));
      if (res_valid) begin
        check("res_valid_pulse", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          check("result_expected", 32'(res_valid), 32'd0);
        end else begin
          logic [25:0] e;
          e = exp_q.pop_front();
          check("result", 32'({res_sensor, res_count, res_timeout}), 32'(e));
        end
        last_res_cyc = cyc;
        have_res     = 1;
      end
      prev_trig  = trig;
      prev_valid = res_valid;
    end
  end

  // driver tasks
  task automatic wait_trig_pulse();
    bit seen;
    seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin tick(); seen = (trig != '0); end
    check("trig_rise_seen", 32'(seen), 32'd1);
    seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin tick(); seen = (trig == '0); end
    check("trig_fall_seen", 32'(seen), 32'd1);
  endtask

  task automatic drive_echo(input int sel, input int dly, input int width, input bit chk_hold);
    wait_trig_pulse();
    // a start request while busy must be ignored
    start_sel   = 3'd0;
    single_shot = 1'b1;
    for (int i = 0; i < dly; i++) begin tick(); single_shot = 1'b0; end
    echo[sel] = 1'b1;
    for (int i = 0; i < width; i++) begin
      tick();
      single_shot = 1'b0;
      if (chk_hold && i == 54) begin
        check("holdoff_while_echo_high", 32'(dbg_state), 32'(ST_HOLDOFF));
        check("echo_still_high", 32'(echo[sel]), 32'd1);
      end
    end
    single_shot = 1'b0;
    echo[sel]   = 1'b0;
  endtask

  task automatic wait_results();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) tick();
    check("results_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && busy; t++) tick();
    check("idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [2:0]    sel;
    bit            pre;
    int            dly;
    int            width;
    logic [CW-1:0] cnt;
    logic [1:0]    to;
    bit            chk_hold;
  } vec_t;

  vec_t tab[10];

  initial begin
    int n0;
    int fall_cyc;

    tab[0] = '{3'd0, 1'b0, 5,  30, 21'd30, TO_OK,     1'b0};
    tab[1] = '{3'd1, 1'b0, 2,  80, 21'd50, TO_LONG,   1'b1};
    tab[2] = '{3'd2, 1'b0, 0,  12, 21'd12, TO_OK,     1'b0};
    tab[3] = '{3'd1, 1'b0, 3,  50, 21'd50, TO_OK,     1'b0};
    tab[4] = '{3'd0, 1'b0, 3,  51, 21'd50, TO_LONG,   1'b0};
    tab[5] = '{3'd2, 1'b0, 4,  1,  21'd1,  TO_OK,     1'b0};
    tab[6] = '{3'd0, 1'b0, 0,  0,  21'd0,  TO_NORISE, 1'b0};
    tab[7] = '{3'd1, 1'b0, 17, 8,  21'd8,  TO_OK,     1'b0};
    tab[8] = '{3'd2, 1'b0, 18, 8,  21'd0,  TO_NORISE, 1'b0};
    tab[9] = '{3'd1, 1'b1, 0,  0,  21'd0,  TO_NORISE, 1'b0};

    rst_n       = 1'b0;
    enable      = 1'b0;
    single_shot = 1'b0;
    start_sel   = 3'd0;
    echo        = '0;
    repeat (3) tick();
    check("rst_trig",        32'(trig),        32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_res_valid",   32'(res_valid),   32'd0);
    check("rst_res_sensor",  32'(res_sensor),  32'd0);
    check("rst_res_count",   32'(res_count),   32'd0);
    check("rst_res_timeout", 32'(res_timeout), 32'd0);
    check("rst_state",       32'(dbg_state),   32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_after_reset", 32'(busy), 32'd0);

    // continuous scan: echo only on first ping, then no-echo wrap, enable dropped in WAIT_RISE
    exp_q.push_back({3'd0, 21'd30, TO_OK});
    exp_q.push_back({3'd1, 21'd0,  TO_NORISE});
    exp_q.push_back({3'd2, 21'd0,  TO_NORISE});
    exp_q.push_back({3'd0, 21'd0,  TO_NORISE});
    enable = 1'b1;
    drive_echo(0, 5, 30, 1'b0);
    for (int t = 0; t < 600 && !(trig_n == 4 && trig == '0); t++) tick();
    check("fourth_trig_done", 32'(trig_n), 32'd4);
    enable = 1'b0;
    wait_results();
    fall_cyc = cyc;
    for (int t = 0; t < 200 && busy; t++) begin tick(); fall_cyc = cyc; end
    check("scan_idle", 32'(busy), 32'd0);
    check_ge("holdoff_served", fall_cyc - last_res_cyc, HOLD);
    repeat (30) tick();
    check("no_trig_after_disable", 32'(trig_n), 32'd4);
    check("scan_order_0", 32'(trig_log[0]), 32'd0);
    check("scan_order_1", 32'(trig_log[1]), 32'd1);
    check("scan_order_2", 32'(trig_log[2]), 32'd2);
    check("scan_order_wrap", 32'(trig_log[3]), 32'd0);

    // single-shot vector table
    for (int v = 0; v < 10; v++) begin
      n0 = trig_n;
      if (tab[v].pre) begin
        echo[tab[v].sel] = 1'b1;
        repeat (4) tick();
      end
      exp_q.push_back({tab[v].sel, tab[v].cnt, tab[v].to});
      start_sel   = tab[v].sel;
      single_shot = 1'b1;
      tick();
      single_shot = 1'b0;
      if (!tab[v].pre && tab[v].width > 0)
        drive_echo(int'(tab[v].sel), tab[v].dly, tab[v].width, tab[v].chk_hold);
      wait_results();
      wait_idle();
      check("vec_one_ping", 32'(trig_n - n0), 32'd1);
      check("vec_sensor", 32'(trig_log[trig_log.size()-1]), 32'(tab[v].sel));
      check("vec_state_idle", 32'(dbg_state), 32'(ST_IDLE));
      echo = '0;
      repeat (5) tick();
    end

    // out-of-range start selections are ignored
    for (int s = 3; s <= 5; s += 2) begin
      n0          = trig_n;
      start_sel   = 3'(s);
      single_shot = 1'b1;
      tick();
      single_shot = 1'b0;
      repeat (20) tick();
      check("bad_sel_not_busy", 32'(busy), 32'd0);
      check("bad_sel_no_trig", 32'(trig_n), 32'(n0));
    end

    // async reset mid-measure
    start_sel   = 3'd2;
    single_shot = 1'b1;
    tick();
    single_shot = 1'b0;
    wait_trig_pulse();
    repeat (3) tick();
    echo[2] = 1'b1;
    repeat (10) tick();
    check("in_measure", 32'(dbg_state), 32'(ST_MEASURE));
    rst_n = 1'b0;
    #1;
    check("arst_trig",      32'(trig),      32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_state",     32'(dbg_state), 32'(ST_IDLE));
    echo = '0;
    repeat (3) tick();
    check("arst_hold_valid", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    exp_q.push_back({3'd0, 21'd0, TO_NORISE});
    enable = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int t = 0; t < 50 && !seen; t++) begin tick(); seen = (trig != '0); end
      check("post_reset_trig_seen", 32'(seen), 32'd1);
    end
    check("post_reset_trig0", 32'(trig), 32'd1);
    enable = 1'b0;
    wait_results();
    wait_idle();
    repeat (20) tick();
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ping_scheduler.md
Name: ultrasonic_ping_scheduler

Overview:
- Sequences trigger/echo ranging cycles for NUM_SENSORS ultrasonic sensors that share one echo-timing datapath.
- Selects sensors round-robin, issues a trigger pulse, times the echo-high width in clock cycles, applies timeouts, enforces an inter-ping holdoff, and posts one result per ping.
- Sits between the sensor pins and the distance-conversion and display logic.

Parameters:
- NUM_SENSORS, 4, number of sensors scheduled; range 1..8.
- TRIG_CYCLES, 270, trigger high width in clk cycles (10 us at 27 MHz).
- ARM_TIMEOUT, 810000, maximum cycles from trigger fall to echo rise (30 ms).
- ECHO_MAX, 1026000, maximum echo-high cycles (38 ms); counter saturates here.
- HOLDOFF_CYCLES, 1620000, minimum cycles from end of one ping to the next trigger (60 ms).
- CNT_W, 21, width of the echo count; must satisfy 2^CNT_W > ECHO_MAX.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = continuous round-robin scanning.
- single_shot  in  1  one-cycle pulse; when idle and enable=0, runs exactly one ping on sensor start_sel.
- start_sel  in  3  sensor index used by single_shot.
- echo  in  NUM_SENSORS  raw asynchronous echo lines, one per sensor.
- trig  out  NUM_SENSORS  trigger lines, one-hot while pulsing, otherwise 0.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  one-cycle pulse when a result is posted.
- res_sensor  out  3  sensor index of the result.
- res_count  out  CNT_W  echo-high width in cycles.
- res_timeout  out  2  00 = ok, 01 = no echo rise, 10 = echo overlong.

Behaviour:
- Reset: all outputs 0, state IDLE, sensor pointer 0, all counters 0, synchronizers cleared.
- Echo conditioning: each echo bit passes through a 2-FF synchronizer. Only the synchronized echo of the selected sensor is used. Rise and fall are detected against the previous synchronized value. Latency from a pin edge to the detected edge is 2 cycles.
- State IDLE:
  - enable=1 → TRIG on the current pointer.
  - Otherwise single_shot=1 → load the pointer from start_sel, then go to TRIG. A start_sel value ≥ NUM_SENSORS is ignored and the block stays in IDLE.
- State TRIG: trig[ptr]=1 for exactly TRIG_CYCLES cycles, then → WAIT_RISE with the counter cleared.
- State WAIT_RISE:
  - Synchronized echo rise → MEASURE with the counter at 1.
  - Counter reaches ARM_TIMEOUT → post a result with count 0 and timeout 01, then → HOLDOFF.
  - If echo is already high on entry to WAIT_RISE, no rise is seen and the ping ends as timeout 01.
- State MEASURE: the counter increments every cycle while synchronized echo=1.
  - Fall → post a result with the count, timeout 00, then → HOLDOFF.
  - Counter reaches ECHO_MAX → post a result with count ECHO_MAX, timeout 10, then → HOLDOFF without waiting for the fall.
- Result posting: res_* are registered. res_valid is high for one cycle, on the cycle after the terminating event. res_sensor/res_count/res_timeout hold their value until the next post.
- State HOLDOFF: waits HOLDOFF_CYCLES and holds the pointer. On exit:
  - Continuous mode: advance the pointer (NUM_SENSORS-1 wraps to 0) → TRIG if enable=1, else → IDLE.
  - Single-shot ping: → IDLE; the pointer is unchanged.
- enable deasserting mid-ping: the current ping completes (result posted, holdoff served), then → IDLE. single_shot while busy is ignored.
- Simultaneous events: the echo fall on the same cycle the counter reaches ECHO_MAX is reported as ok (00) with count ECHO_MAX.
- NUM_SENSORS=1: the pointer is constant 0.
- Asynchronous reset mid-ping: trig drops immediately and no result is posted.

Decomposition:
- Shared package ranging_pkg:
  - State enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF).
  - Timeout code constants TO_OK, TO_NORISE, TO_LONG.
  - Default timing constants for 27 MHz.
- One sub-module, echo_sync: per-bit 2-FF synchronizer plus registered previous value, with rise/fall outputs. The FSM and counters stay in the top level.

Test Plan (sim overrides: TRIG_CYCLES=4, ARM_TIMEOUT=20, ECHO_MAX=50, HOLDOFF_CYCLES=10, NUM_SENSORS=3):
- enable=1, echo[0] high 30 cycles starting 5 cycles after trig falls → trig[0] high exactly 4 cycles; res_valid with sensor 0, count 30, timeout 00; next trig is trig[1] after ≥10 holdoff cycles.
- enable=1, no echo on any sensor → three results (sensors 0,1,2), each with count 0 and timeout 01; the fourth trigger is trig[0] again (wrap).
- echo[1] held high 80 cycles → result with sensor 1, count 50, timeout 10; the block enters HOLDOFF while echo is still high.
- enable=0, single_shot with start_sel=2, echo 12 cycles → one ping on sensor 2, result count 12, then IDLE with busy=0 and no further trigs; single_shot with start_sel=5 → no activity.
- rst_n low during MEASURE → trig=0, res_valid=0, busy=0 immediately; after release with enable=1, the first trigger is trig[0].
- enable dropped during WAIT_RISE → the ping finishes (timeout 01 posted), holdoff is served, then IDLE with no further trigger.
